ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RISC-V core.
- Owns the sequencing of the EX stage:
  - inserts a load-use bubble ahead of the EX forwarding network;
  - flushes IF/ID and ID/EX on a taken branch or jump;
  - holds EX for multi-cycle multiply/divide operations via a countdown FSM.
- Drives the write-enable and flush controls of PC, IF/ID, ID/EX and EX/MEM.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MUL_LAT, 2, busy cycles of a multiply in EX (at least 1).
- DIV_LAT, 32, busy cycles of a divide/remainder in EX (at least 1).
- CNT_W, 6, countdown width; must hold max(MUL_LAT, DIV_LAT)-1.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- MemRead_ex  input  1  instruction in EX is a load.
- rdAddr_ex  input  5  destination register of the instruction in EX.
- rs1Addr_id  input  5  rs1 of the instruction in ID.
- rs2Addr_id  input  5  rs2 of the instruction in ID.
- rs1Used_id  input  1  the ID instruction reads rs1.
- rs2Used_id  input  1  the ID instruction reads rs2.
- BranchTaken_ex  input  1  branch/jump in EX redirects the PC.
- MulDiv_ex  input  1  instruction in EX is an M-extension operation.
- IsDiv_ex  input  1  that operation is div/divu/rem/remu.
- PC_IFWrite  output  1  PC and IF/ID write enable.
- IF_ID_Flush  output  1  zero the IF/ID register.
- ID_EX_Write  output  1  ID/EX write enable.
- ID_EX_Flush  output  1  load a bubble into ID/EX.
- EX_MEM_Flush  output  1  load a bubble into EX/MEM.
- MulDivBusy  output  1  multi-cycle operation in progress.
- MulDivDone  output  1  EX result of the multi-cycle operation is valid this cycle.
- StallCount  output  32  saturating count of cycles with PC_IFWrite=0.

Behaviour:
- FSM states: IDLE, BUSY, DONE. The state register and countdown cnt are the only sequential state, apart from StallCount.
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, StallCount=0.
  - Outputs under reset: PC_IFWrite=1, ID_EX_Write=1, every flush=0, MulDivBusy=0, MulDivDone=0.
- All control outputs are combinational from state and inputs. Priority order: branch > muldiv > load-use.
- IDLE, BranchTaken_ex=1:
  - IF_ID_Flush=1, ID_EX_Flush=1, PC_IFWrite=1.
  - Stay in IDLE. MulDiv_ex is ignored in this case (illegal combination).
- IDLE, MulDiv_ex=1 (issue cycle):
  - PC_IFWrite=0, ID_EX_Write=0, EX_MEM_Flush=1, MulDivBusy=1.
  - cnt is loaded with (IsDiv_ex ? DIV_LAT : MUL_LAT)-1; go to BUSY.
- IDLE, load-use hazard:
  - Hazard condition: MemRead_ex && rdAddr_ex!=0 && ((rs1Used_id && rs1Addr_id==rdAddr_ex) || (rs2Used_id && rs2Addr_id==rdAddr_ex)).
  - Response: PC_IFWrite=0, ID_EX_Flush=1 for exactly one cycle. No state change.
  - x0 never causes a hazard.
- BUSY:
  - PC_IFWrite=0, ID_EX_Write=0, EX_MEM_Flush=1, MulDivBusy=1.
  - If cnt==0, go to DONE; otherwise decrement cnt.
  - Load-use and BranchTaken_ex are ignored (EX holds a muldiv).
- DONE (one cycle):
  - MulDivDone=1, MulDivBusy=0, PC_IFWrite=1, ID_EX_Write=1, EX_MEM_Flush=0.
  - The result advances to MEM at the end of this cycle. Always return to IDLE.
  - MulDiv_ex still high in DONE does not retrigger.
- EX occupancy of a muldiv is LAT+2 cycles: issue + LAT BUSY + DONE. Back-to-back muldiv ops each restart from IDLE.
- StallCount increments on each cycle with PC_IFWrite=0 and saturates at 32'hFFFFFFFF.
- Reset asserted mid-BUSY aborts immediately to IDLE. The pending operation is discarded and MulDivDone is never raised for it.
- Flush and write-enable never conflict: whenever ID_EX_Flush=1, ID_EX_Write=1.

Test Plan:
- Load-use: MemRead_ex=1, rdAddr_ex=5, rs2Used_id=1, rs2Addr_id=5 for 1 cycle. Required: PC_IFWrite=0 and ID_EX_Flush=1 for exactly 1 cycle; StallCount goes 0 to 1. Repeating with rdAddr_ex=0 gives no stall.
- Branch: BranchTaken_ex=1 with a coincident load-use pattern. Required: IF_ID_Flush=1, ID_EX_Flush=1, PC_IFWrite=1; StallCount unchanged.
- Multiply, MUL_LAT=2: MulDiv_ex=1, IsDiv_ex=0 held. Required: MulDivBusy high for 3 cycles, then MulDivDone high for 1 cycle, then IDLE; StallCount=3.
- Divide, DIV_LAT=32: MulDiv_ex=1, IsDiv_ex=1. Required: 33 stall cycles, then DONE on cycle 34; EX_MEM_Flush=1 for exactly 33 cycles.
- Abort: rst_n pulsed low for 1 cycle at BUSY cycle 10 of a divide. Required: outputs return to reset values asynchronously, MulDivDone is never asserted, StallCount=0.
- Back-to-back: two consecutive multiplies. Required: DONE, then IDLE issue, then BUSY; two separate MulDivDone pulses 4 cycles apart.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ex_hazard_ctrl
// Brief    : EX-stage hazard/stall sequencer for the 5-stage RISC-V core.
//            Load-use bubbles, branch/jump flushes, multi-cycle mul/div hold
//            and a saturating stall-cycle counter for performance debug.
// Revision : 1.0  initial release
// ============================================================================
module ex_hazard_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_ex,
    input  logic [4:0]  rdAddr_ex,
    input  logic [4:0]  rs1Addr_id,
    input  logic [4:0]  rs2Addr_id,
    input  logic        rs1Used_id,
    input  logic        rs2Used_id,
    input  logic        BranchTaken_ex,
    input  logic        MulDiv_ex,
    input  logic        IsDiv_ex,
    output logic        PC_IFWrite,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Write,
    output logic        ID_EX_Flush,
    output logic        EX_MEM_Flush,
    output logic        MulDivBusy,
    output logic        MulDivDone,
    output logic [31:0] StallCount
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Countdown preloads: the issue cycle is not counted, so LAT-1 leaves
    // exactly LAT cycles spent in BUSY (cnt runs LAT-1 .. 0).
    localparam logic [CNT_W-1:0] c_mul_ld  = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] c_div_ld  = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_stall_cnt;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_load_use;

    // A load in EX feeding a source read by ID; x0 is hard-wired and never stalls.
    always_comb begin
        w_load_use = MemRead_ex && (rdAddr_ex != 5'd0) &&
                     ((rs1Used_id && (rs1Addr_id == rdAddr_ex)) ||
                      (rs2Used_id && (rs2Addr_id == rdAddr_ex)));
    end

    // Pipeline controls and next state; priority branch > muldiv > load-use.
    always_comb begin
        PC_IFWrite   = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Write  = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        MulDivBusy   = 1'b0;
        MulDivDone   = 1'b0;
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        // While reset is held every control sits at its pass-through value,
        // regardless of what the upstream stages present.
        if (rst_n) begin
            case (r_state)
                c_st_busy: begin
                    PC_IFWrite   = 1'b0;
                    ID_EX_Write  = 1'b0;
                    EX_MEM_Flush = 1'b1;
                    MulDivBusy   = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = c_st_done;
                    end else begin
                        w_cnt_nxt = r_cnt - c_cnt_one;
                    end
                end
                c_st_done: begin
                    // Result leaves EX this cycle; a still-high MulDiv_ex is the
                    // same instruction and must not restart the sequence.
                    MulDivDone  = 1'b1;
                    w_state_nxt = c_st_idle;
                end
                default: begin
                    w_state_nxt = c_st_idle;
                    if (BranchTaken_ex) begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                    end else if (MulDiv_ex) begin
                        PC_IFWrite   = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_MEM_Flush = 1'b1;
                        MulDivBusy   = 1'b1;
                        w_cnt_nxt    = IsDiv_ex ? c_div_ld : c_mul_ld;
                        w_state_nxt  = c_st_busy;
                    end else if (w_load_use) begin
                        PC_IFWrite  = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end
                end
            endcase
        end
    end

    // FSM state and countdown; reset discards any in-flight mul/div.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Saturating count of cycles in which fetch was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
        end else if (!PC_IFWrite && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign StallCount = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_hazard_ctrl
// Brief    : Directed self-checking bench for ex_hazard_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        MemRead_ex;
    logic [4:0]  rdAddr_ex;
    logic [4:0]  rs1Addr_id;
    logic [4:0]  rs2Addr_id;
    logic        rs1Used_id;
    logic        rs2Used_id;
    logic        BranchTaken_ex;
    logic        MulDiv_ex;
    logic        IsDiv_ex;
    logic        PC_IFWrite;
    logic        IF_ID_Flush;
    logic        ID_EX_Write;
    logic        ID_EX_Flush;
    logic        EX_MEM_Flush;
    logic        MulDivBusy;
    logic        MulDivDone;
    logic [31:0] StallCount;

    // Output bundle: {PC_IFWrite, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
    //                 EX_MEM_Flush, MulDivBusy, MulDivDone}
    logic [6:0] w_outs;
    assign w_outs = {PC_IFWrite, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
                     EX_MEM_Flush, MulDivBusy, MulDivDone};

    localparam logic [6:0] c_o_idle = 7'b1010000;
    localparam logic [6:0] c_o_lu   = 7'b0011000;
    localparam logic [6:0] c_o_br   = 7'b1111000;
    localparam logic [6:0] c_o_busy = 7'b0000110;
    localparam logic [6:0] c_o_done = 7'b1010001;

    int errors;
    int checks;
    logic [31:0] exp_stall;

    ex_hazard_ctrl #(
        .MUL_LAT (2),
        .DIV_LAT (32),
        .CNT_W   (6)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .MemRead_ex     (MemRead_ex),
        .rdAddr_ex      (rdAddr_ex),
        .rs1Addr_id     (rs1Addr_id),
        .rs2Addr_id     (rs2Addr_id),
        .rs1Used_id     (rs1Used_id),
        .rs2Used_id     (rs2Used_id),
        .BranchTaken_ex (BranchTaken_ex),
        .MulDiv_ex      (MulDiv_ex),
        .IsDiv_ex       (IsDiv_ex),
        .PC_IFWrite     (PC_IFWrite),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Write    (ID_EX_Write),
        .ID_EX_Flush    (ID_EX_Flush),
        .EX_MEM_Flush   (EX_MEM_Flush),
        .MulDivBusy     (MulDivBusy),
        .MulDivDone     (MulDivDone),
        .StallCount     (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge (input drive point).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        MemRead_ex     = 1'b0;
        rdAddr_ex      = 5'd0;
        rs1Addr_id     = 5'd0;
        rs2Addr_id     = 5'd0;
        rs1Used_id     = 1'b0;
        rs2Used_id     = 1'b0;
        BranchTaken_ex = 1'b0;
        MulDiv_ex      = 1'b0;
        IsDiv_ex       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        // Hazard-looking inputs while in reset must not disturb the outputs.
        MemRead_ex = 1'b1; rdAddr_ex = 5'd5; rs2Used_id = 1'b1; rs2Addr_id = 5'd5;
        MulDiv_ex = 1'b1;
        #1;
        checks++;
        if (w_outs !== c_o_idle) begin
            errors++;
            $display("FAIL reset_outs: got %b want %b", w_outs, c_o_idle);
        end
        checks++;
        if (StallCount !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall: got %0d want 0", StallCount);
        end
        clear_inputs();
        cyc();
        cyc();
        rst_n = 1'b1;
        exp_stall = 32'd0;
        cyc();
        #1;
        checks++;
        if (w_outs !== c_o_idle || StallCount !== 32'd0) begin
            errors++;
            $display("FAIL reset_release: got %b/%0d want %b/0", w_outs, StallCount, c_o_idle);
        end
    endtask

    task automatic test_load_use();
        // rs2 match on r5
        cyc();
        MemRead_ex = 1'b1; rdAddr_ex = 5'd5; rs2Used_id = 1'b1; rs2Addr_id = 5'd5;
        rs1Used_id = 1'b1; rs1Addr_id = 5'd3;
        #1;
        checks++;
        if (w_outs !== c_o_lu || StallCount !== exp_stall) begin
            errors++;
            $display("FAIL lu_rs2: got %b/%0d want %b/%0d", w_outs, StallCount, c_o_lu, exp_stall);
        end
        exp_stall = exp_stall + 32'd1;
        cyc();
        clear_inputs();
        #1;
        checks++;
        if (w_outs !== c_o_idle || StallCount !== exp_stall) begin
            errors++;
            $display("FAIL lu_after: got %b/%0d want %b/%0d", w_outs, StallCount, c_o_idle, exp_stall);
        end
        // rs1 match on r7
        cyc();
        MemRead_ex = 1'b1; rdAddr_ex = 5'd7; rs1Used_id = 1'b1; rs1Addr_id = 5'd7;
        #1;
        checks++;
        if (w_outs !== c_o_lu) begin
            errors++;
            $display("FAIL lu_rs1: got %b want %b", w_outs, c_o_lu);
        end
        exp_stall = exp_stall + 32'd1;
        // address match but rs1 not read -> no hazard
        cyc();
        rs1Used_id = 1'b0;
        #1;
        checks++;
        if (w_outs !== c_o_idle) begin
            errors++;
            $display("FAIL lu_unused: got %b want %b", w_outs, c_o_idle);
        end
        // not a load -> no hazard
        cyc();
        rs1Used_id = 1'b1; MemRead_ex = 1'b0;
        #1;
        checks++;
        if (w_outs !== c_o_idle) begin
            errors++;
            $display("FAIL lu_noload: got %b want %b", w_outs, c_o_idle);
        end
        // x0 destination -> no hazard
        cyc();
        MemRead_ex = 1'b1; rdAddr_ex = 5'd0; rs1Addr_id = 5'd0;
        rs2Used_id = 1'b1; rs2Addr_id = 5'd0;
        #1;
        checks++;
        if (w_outs !== c_o_idle) begin
            errors++;
            $display("FAIL lu_x0: got %b want %b", w_outs, c_o_idle);
        end
        cyc();
        clear_inputs();
        #1;
        checks++;
        if (StallCount !== exp_stall) begin
            errors++;
            $display("FAIL lu_count: got %0d want %0d", StallCount, exp_stall);
        end
    endtask

    task automatic test_branch();
        cyc();
        BranchTaken_ex = 1'b1; MulDiv_ex = 1'b1;
        MemRead_ex = 1'b1; rdAddr_ex = 5'd5; rs2Used_id = 1'b1; rs2Addr_id = 5'd5;
        #1;
        checks++;
        if (w_outs !== c_o_br) begin
            errors++;
            $display("FAIL branch_outs: got %b want %b", w_outs, c_o_br);
        end
        cyc();
        clear_inputs();
        #1;
        checks++;
        if (w_outs !== c_o_idle || StallCount !== exp_stall) begin
            errors++;
            $display("FAIL branch_after: got %b/%0d want %b/%0d", w_outs, StallCount, c_o_idle, exp_stall);
        end
    endtask

    task automatic test_mul();
        logic [6:0] exp_o;
        for (int i = 0; i < 4; i++) begin
            cyc();
            MulDiv_ex = 1'b1; IsDiv_ex = 1'b0;
            BranchTaken_ex = (i == 1);
            #1;
            exp_o = (i < 3) ? c_o_busy : c_o_done;
            checks++;
            if (w_outs !== exp_o) begin
                errors++;
                $display("FAIL mul_cycle%0d: got %b want %b", i, w_outs, exp_o);
            end
        end
        exp_stall = exp_stall + 32'd3;
        cyc();
        clear_inputs();
        #1;
        checks++;
        if (w_outs !== c_o_idle || StallCount !== exp_stall) begin
            errors++;
            $display("FAIL mul_after: got %b/%0d want %b/%0d", w_outs, StallCount, c_o_idle, exp_stall);
        end
    endtask

    task automatic test_div();
        logic [6:0] exp_o;
        int flush_cycles;
        flush_cycles = 0;
        for (int i = 0; i < 34; i++) begin
            cyc();
            MulDiv_ex = 1'b1; IsDiv_ex = 1'b1;
            #1;
            if (EX_MEM_Flush === 1'b1) flush_cycles++;
            exp_o = (i < 33) ? c_o_busy : c_o_done;
            checks++;
            if (w_outs !== exp_o) begin
                errors++;
                $display("FAIL div_cycle%0d: got %b want %b", i, w_outs, exp_o);
            end
        end
        exp_stall = exp_stall + 32'd33;
        cyc();
        clear_inputs();
        #1;
        checks++;
        if (flush_cycles != 33) begin
            errors++;
            $display("FAIL div_flush_len: got %0d want 33", flush_cycles);
        end
        checks++;
        if (w_outs !== c_o_idle || StallCount !== exp_stall) begin
            errors++;
            $display("FAIL div_after: got %b/%0d want %b/%0d", w_outs, StallCount, c_o_idle, exp_stall);
        end
    endtask

    task automatic test_abort();
        int done_seen;
        done_seen = 0;
        // issue (i=0) then BUSY cycles 1..10
        for (int i = 0; i <= 10; i++) begin
            cyc();
            MulDiv_ex = 1'b1; IsDiv_ex = 1'b1;
        end
        #2;
        rst_n = 1'b0;
        MulDiv_ex = 1'b0; IsDiv_ex = 1'b0;
        #1;
        checks++;
        if (w_outs !== c_o_idle || StallCount !== 32'd0) begin
            errors++;
            $display("FAIL abort_async: got %b/%0d want %b/0", w_outs, StallCount, c_o_idle);
        end
        exp_stall = 32'd0;
        #7;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (MulDivDone !== 1'b0 || w_outs !== c_o_idle) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d non-idle cycles want 0", done_seen);
        end
        checks++;
        if (StallCount !== exp_stall) begin
            errors++;
            $display("FAIL abort_stall: got %0d want %0d", StallCount, exp_stall);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_o;
        int first_done;
        int second_done;
        first_done  = -1;
        second_done = -1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            MulDiv_ex = 1'b1; IsDiv_ex = 1'b0;
            #1;
            if (MulDivDone === 1'b1) begin
                if (first_done < 0) first_done = i;
                else second_done = i;
            end
            exp_o = (i == 3 || i == 7) ? c_o_done : c_o_busy;
            checks++;
            if (w_outs !== exp_o) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got %b want %b", i, w_outs, exp_o);
            end
        end
        exp_stall = exp_stall + 32'd6;
        cyc();
        clear_inputs();
        #1;
        checks++;
        if (second_done - first_done != 4 || first_done != 3) begin
            errors++;
            $display("FAIL b2b_spacing: got done at %0d,%0d want 3,7", first_done, second_done);
        end
        checks++;
        if (w_outs !== c_o_idle || StallCount !== exp_stall) begin
            errors++;
            $display("FAIL b2b_after: got %b/%0d want %b/%0d", w_outs, StallCount, c_o_idle, exp_stall);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        exp_stall = 32'd0;
        rst_n     = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_mul();
        test_div();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
